prog_ram: RTL and testbench
===========================

PROG_RAM -- requirements
Module: prog_ram

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 4, address width in bits; depth DEPTH = 2**ADDR_W words.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESETn  input  1  reset, synchronous, active-low.
REQ-005 ADDR  input  ADDR_W  CPU word address.
REQ-006 DIN  input  DATA_W  CPU write data.
REQ-007 RI  input  1  CPU write strobe; high writes DIN to ADDR.
REQ-008 DOUT  output  DATA_W  CPU read data.
REQ-009 LD_START  input  1  one-cycle request to start a sequential program load.
REQ-010 LD_VALID  input  1  loader data valid.
REQ-011 LD_DATA  input  DATA_W  loader data word.
REQ-012 LD_READY  output  1  block accepts a loader word this cycle.
REQ-013 BUSY  output  1  block owns the memory; CPU accesses are blocked.
REQ-014 LD_DONE  output  1  one-cycle pulse after the last load word is written.

Function
REQ-015 Storage read is synchronous: the word at ADDR sampled at edge N appears on the internal read bus after edge N (1-cycle latency).
REQ-016 DOUT SHALL be all-zero whenever RI=1 or BUSY=1; otherwise it is the internal read bus.
REQ-017 CPU write: RI=1 and BUSY=0 at an edge writes DIN to ADDR; RI=1 while BUSY=1 is ignored.
REQ-018 FSM states: CLEAR, IDLE, LOAD.
REQ-019 IDLE: BUSY=0, LD_READY=0; LD_START=1 moves to LOAD with address counter = 0.
REQ-020 LOAD: BUSY=1, LD_READY=1; each edge with LD_VALID=1 writes LD_DATA at counter and increments counter; LD_VALID=0 stalls indefinitely with no write.
REQ-021 Write accepted at counter = DEPTH-1 moves to IDLE; LD_DONE=1 for exactly the following cycle; counter wraps to 0.
REQ-022 LD_START in LOAD or CLEAR is ignored; LD_START and RI in the same IDLE cycle: the CPU write is performed, then LOAD begins.
REQ-023 LD_VALID outside LOAD is ignored, no write.
REQ-024 Counter is ADDR_W bits, unsigned, modulo DEPTH.

Reset
REQ-025 RESETn=0 at an edge: state -> CLEAR (macro defined) or IDLE (undefined); counter=0; LD_DONE=0; LD_READY=0; BUSY per the entered state; DOUT=0 in the following cycle.
REQ-026 Reset mid-LOAD abandons the load without LD_DONE; already-written words persist.
REQ-027 Storage contents are not reset except by CLEAR.

Configuration
REQ-028 Macro PROG_RAM_CLEAR_EN defined: after reset the FSM enters CLEAR, writes 0 to addresses 0..DEPTH-1 one per cycle with BUSY=1, LD_READY=0, then enters IDLE (exactly DEPTH cycles of BUSY after reset release).
REQ-029 Macro undefined: no CLEAR state; reset enters IDLE directly; contents after power-up are undefined.

Structure
REQ-030 Shared package be8_pkg holds default DATA_W/ADDR_W constants and the FSM state typedef.
REQ-031 One sub-module ram_array: parametrised single-port synchronous RAM (EN, WE, A, Di, Do); prog_ram muxes its address/data/WE between CPU, loader and clear counter.

Verification
REQ-032 Defaults, CPU writes 8'hA5 to addr 3 (RI=1), then ADDR=3, RI=0 -> DOUT=8'hA5 one cycle later; DOUT=0 during the write cycle.
REQ-033 LD_START, then 16 words 8'h10..8'h1F with LD_VALID toggled every other cycle -> LD_DONE one pulse after the 16th write, BUSY 0 next; reading addr 0..15 returns 8'h10..8'h1F.
REQ-034 RI=1, DIN=8'hFF, ADDR=5 during LOAD -> addr 5 holds loader value, DOUT=0 throughout LOAD.
REQ-035 RESETn low after 7 load words -> no LD_DONE, BUSY drops (or CLEAR runs); addr 0..6 hold loaded data (macro undefined).
REQ-036 PROG_RAM_CLEAR_EN defined, reset released -> BUSY=1 for 16 cycles, LD_START ignored; all 16 addresses then read 8'h00.
REQ-037 Parameters DATA_W=12, ADDR_W=6 -> full 64-word load and readback pass; counter wraps to 0 after address 63.

Source files
------------

// File: rtl/be8_pkg.sv
// Shared constants and FSM state type for the program RAM.
package be8_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  // ST_CLEAR only becomes reachable when PROG_RAM_CLEAR_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM with read-before-write behaviour.
// The read data is registered, so a read has one cycle of latency.
module ram_array
  import be8_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              EN,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Di,
  output logic [DATA_W-1:0] Do
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Registered read of the old word, with an optional write to the same address.
  always_ff @(posedge CLK) begin
    if (EN) begin
      if (WE) begin
        mem[A] <= Di;
      end
      Do <= mem[A];
    end
  end

endmodule

// File: rtl/prog_ram.sv
// Program RAM with a CPU port and a sequential loader port.
// The loader takes over the memory while it runs and blocks CPU accesses.
// Optional feature: PROG_RAM_CLEAR_EN zero-fills the array after every reset.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | CPU owns the RAM; LD_START begins a load at address 0
//   ST_LOAD  | loader owns the RAM; one word per LD_VALID cycle
//   ST_CLEAR | writes zero to every address, then returns to ST_IDLE
module prog_ram
  import be8_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  input  logic              RI,
  output logic [DATA_W-1:0] DOUT,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              LD_READY,
  output logic              BUSY,
  output logic              LD_DONE
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              busy_q;
  logic              ld_ready_q;
  logic              ld_done_q;
  logic              dout_mask_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_di;
  logic [DATA_W-1:0] rd_bus;

  // Route the RAM port to the CPU, the loader or the clear sweep.
  always_comb begin
    ram_a  = ADDR;
    ram_di = DIN;
    ram_we = 1'b0;
    case (state)
      ST_IDLE: begin
        ram_we = RI;
      end
      ST_LOAD: begin
        ram_a  = cnt;
        ram_di = LD_DATA;
        ram_we = LD_VALID;
      end
`ifdef PROG_RAM_CLEAR_EN
      ST_CLEAR: begin
        ram_a  = cnt;
        ram_di = '0;
        ram_we = 1'b1;
      end
`endif
      default: begin
        ram_we = 1'b0;
      end
    endcase
    // A reset edge must not corrupt memory, so contents survive an aborted load.
    if (!RESETn) begin
      ram_we = 1'b0;
    end
  end

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK (CLK),
    .EN  (1'b1),
    .WE  (ram_we),
    .A   (ram_a),
    .Di  (ram_di),
    .Do  (rd_bus)
  );

  // Sequencing FSM with registered status outputs.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
`ifdef PROG_RAM_CLEAR_EN
      state  <= ST_CLEAR;
      busy_q <= 1'b1;
`else
      state  <= ST_IDLE;
      busy_q <= 1'b0;
`endif
      cnt         <= '0;
      ld_ready_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      dout_mask_q <= 1'b1;
    end else begin
      ld_done_q   <= 1'b0;
      dout_mask_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (LD_START) begin
            state      <= ST_LOAD;
            cnt        <= '0;
            busy_q     <= 1'b1;
            ld_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (LD_VALID) begin
            cnt <= cnt + ADDR_W'(1);
            if (cnt == LAST) begin
              state      <= ST_IDLE;
              busy_q     <= 1'b0;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
            end
          end
        end
`ifdef PROG_RAM_CLEAR_EN
        ST_CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == LAST) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
`endif
        default: begin
          state      <= ST_IDLE;
          cnt        <= '0;
          busy_q     <= 1'b0;
          ld_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // The read bus is hidden while writing, while busy and right after reset.
  assign DOUT     = (RI || busy_q || dout_mask_q) ? '0 : rd_bus;
  assign BUSY     = busy_q;
  assign LD_READY = ld_ready_q;
  assign LD_DONE  = ld_done_q;

endmodule

// File: tb/tb_prog_ram.sv
// Directed testbench for prog_ram: default 8x16 instance and a 12x64 instance.
module tb_prog_ram;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  addr;
  logic [7:0]  din;
  logic        ri;
  logic [7:0]  dout;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        busy;
  logic        ld_done;

  logic [5:0]  addr_b;
  logic [11:0] din_b;
  logic        ri_b;
  logic [11:0] dout_b;
  logic        ld_start_b;
  logic        ld_valid_b;
  logic [11:0] ld_data_b;
  logic        ld_ready_b;
  logic        busy_b;
  logic        ld_done_b;

  int pass_cnt = 0;
  int total    = 0;

`ifdef PROG_RAM_CLEAR_EN
  localparam logic RST_BUSY = 1'b1;
`else
  localparam logic RST_BUSY = 1'b0;
`endif

  always #5 clk = ~clk;

  prog_ram u0 (
    .CLK      (clk),
    .RESETn   (rst_n),
    .ADDR     (addr),
    .DIN      (din),
    .RI       (ri),
    .DOUT     (dout),
    .LD_START (ld_start),
    .LD_VALID (ld_valid),
    .LD_DATA  (ld_data),
    .LD_READY (ld_ready),
    .BUSY     (busy),
    .LD_DONE  (ld_done)
  );

  prog_ram #(.DATA_W(12), .ADDR_W(6)) u1 (
    .CLK      (clk),
    .RESETn   (rst_n),
    .ADDR     (addr_b),
    .DIN      (din_b),
    .RI       (ri_b),
    .DOUT     (dout_b),
    .LD_START (ld_start_b),
    .LD_VALID (ld_valid_b),
    .LD_DATA  (ld_data_b),
    .LD_READY (ld_ready_b),
    .BUSY     (busy_b),
    .LD_DONE  (ld_done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    addr = a;
    ri   = 1'b0;
    tick();
    chk(tag, 32'(dout), 32'(exp));
  endtask

  task automatic rd_b(input logic [5:0] a, input logic [11:0] exp, input string tag);
    addr_b = a;
    ri_b   = 1'b0;
    tick();
    chk(tag, 32'(dout_b), 32'(exp));
  endtask

  task automatic after_reset();
`ifdef PROG_RAM_CLEAR_EN
    repeat (70) tick();
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    addr = '0; din = '0; ri = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    addr_b = '0; din_b = '0; ri_b = 1'b0;
    ld_start_b = 1'b0; ld_valid_b = 1'b0; ld_data_b = '0;

    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'(RST_BUSY));
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    rst_n = 1'b1;

`ifdef PROG_RAM_CLEAR_EN
    begin
      int n;
      n = 0;
      ld_start = 1'b1;
      for (int i = 0; i < 40 && busy; i++) begin
        tick();
        n++;
        if (n == 3) ld_start = 1'b0;
      end
      ld_start = 1'b0;
      chk("clear_busy_cycles", 32'(n), 32'd16);
      chk("clear_start_ignored", 32'(ld_ready), 32'd0);
      repeat (60) tick();
      for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, "clear_read");
    end
`endif

    // CPU write and read back
    addr = 4'd3; din = 8'hA5; ri = 1'b1;
    #1;
    chk("dout_during_write", 32'(dout), 32'd0);
    tick();
    rd(4'd3, 8'hA5, "cpu_rd3");
    addr = 4'd9; din = 8'h5A; ri = 1'b1;
    tick();
    rd(4'd9, 8'h5A, "cpu_rd9");
    rd(4'd3, 8'hA5, "cpu_rd3_again");

    // Full load with a stall before every word
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      ri = (i < 8); din = 8'hFF; addr = 4'd5;
      ld_valid = 1'b0;
      tick();
      chk("stall_no_done", 32'(ld_done), 32'd0);
      ld_valid = 1'b1;
      ld_data  = 8'h10 + 8'(i);
      if (i == 15) ri = 1'b0;
      tick();
      if (i == 15) begin
        chk("load_done_pulse", 32'(ld_done), 32'd1);
        chk("load_busy_low", 32'(busy), 32'd0);
      end else begin
        chk("load_dout_zero", 32'(dout), 32'd0);
      end
    end
    ld_valid = 1'b0;
    ri = 1'b0;
    tick();
    chk("done_one_cycle", 32'(ld_done), 32'd0);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h10 + 8'(i), "load_read");

    // Reset after seven load words
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h20 + 8'(i);
      tick();
    end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("abort_no_done", 32'(ld_done), 32'd0);
    chk("abort_busy", 32'(busy), 32'(RST_BUSY));
    chk("abort_dout", 32'(dout), 32'd0);
    rst_n = 1'b1;
    after_reset();
`ifndef PROG_RAM_CLEAR_EN
    for (int i = 0; i < 7; i++) rd(4'(i), 8'h20 + 8'(i), "abort_read");
    rd(4'd7, 8'h17, "abort_untouched");

    // Loader strobe while idle writes nothing
    ld_valid = 1'b1; ld_data = 8'hEE;
    tick();
    ld_valid = 1'b0;
    chk("idle_valid_no_busy", 32'(busy), 32'd0);
    rd(4'd0, 8'h20, "idle_valid_no_write");
`endif

    // CPU write and LD_START in the same idle cycle
    ri = 1'b1; addr = 4'd10; din = 8'h77; ld_start = 1'b1;
    tick();
    ri = 1'b0; ld_start = 1'b0;
    chk("start_with_ri_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_start = (i == 1);
      ld_data  = 8'h30 + 8'(i);
      tick();
    end
    ld_valid = 1'b0; ld_start = 1'b0;
    chk("start_in_load_ignored", 32'(ld_ready), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    after_reset();
`ifndef PROG_RAM_CLEAR_EN
    rd(4'd10, 8'h77, "cpu_write_before_load");
    for (int i = 0; i < 3; i++) rd(4'(i), 8'h30 + 8'(i), "short_load_read");
    rd(4'd3, 8'h23, "short_load_untouched");
`endif

    // Wide instance: 64-word load, readback and counter wrap
    ld_start_b = 1'b1;
    tick();
    ld_start_b = 1'b0;
    chk("b_busy", 32'(busy_b), 32'd1);
    for (int i = 0; i < 64; i++) begin
      ld_valid_b = 1'b1;
      ld_data_b  = 12'hA00 | 12'(i);
      tick();
      if (i == 62) chk("b_no_early_done", 32'(ld_done_b), 32'd0);
    end
    ld_valid_b = 1'b0;
    chk("b_done", 32'(ld_done_b), 32'd1);
    chk("b_idle", 32'(busy_b), 32'd0);
    tick();
    for (int i = 0; i < 64; i++) rd_b(6'(i), 12'hA00 | 12'(i), "b_read");
    ld_start_b = 1'b1;
    tick();
    ld_start_b = 1'b0;
    ld_valid_b = 1'b1; ld_data_b = 12'h5C3;
    tick();
    ld_valid_b = 1'b0;
    chk("b_still_loading", 32'(busy_b), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    after_reset();
`ifndef PROG_RAM_CLEAR_EN
    rd_b(6'd0, 12'h5C3, "b_wrap_addr0");
    rd_b(6'd1, 12'hA01, "b_wrap_addr1");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
